// File: rtl/armv8_pkg.sv
// Shared LEGv8 opcodes, ALU op encodings and the ID/EX control bundle.
package armv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_PASSB = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;

    typedef struct packed {
        logic valid;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
        logic branch;
        logic uncondbr;
    } ctrl_t;

endpackage

// File: rtl/armv8_ctrl_decode.sv
// Combinational LEGv8 decode: opcode to controls, register fields, sign-extended immediate.
module armv8_ctrl_decode
    import armv8_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic [31:0]        instr,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] aluop,
    output logic [REG_AW-1:0]  rd,
    output logic [REG_AW-1:0]  rn,
    output logic [REG_AW-1:0]  rm,
    output logic               uses_rm,
    output logic [DATA_W-1:0]  signext
);

    logic [10:0] op11;
    logic is_r, is_ldur, is_stur, is_cbz, is_b;

    assign op11    = instr[31:21];
    assign is_r    = (op11 == OP_ADD) || (op11 == OP_SUB)
                   || (op11 == OP_AND) || (op11 == OP_ORR);
    assign is_ldur = (op11 == OP_LDUR);
    assign is_stur = (op11 == OP_STUR);
    assign is_cbz  = (instr[31:24] == OP_CBZ);
    assign is_b    = (instr[31:26] == OP_B);

    assign rd      = REG_AW'(instr[4:0]);
    assign rn      = REG_AW'(instr[9:5]);
    assign rm      = is_r ? REG_AW'(instr[20:16]) : REG_AW'(instr[4:0]);
    assign uses_rm = is_r | is_stur | is_cbz;

    always_comb begin
        ctrl    = '0;
        aluop   = '0;
        signext = '0;
        unique case (1'b1)
            is_r: begin
                ctrl.regwrite = 1'b1;
                aluop         = ALUOP_W'(ALUOP_RTYPE);
            end
            is_ldur: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                aluop         = ALUOP_W'(ALUOP_ADD);
                signext       = {{(DATA_W-9){instr[20]}}, instr[20:12]};
            end
            is_stur: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                aluop         = ALUOP_W'(ALUOP_ADD);
                signext       = {{(DATA_W-9){instr[20]}}, instr[20:12]};
            end
            is_cbz: begin
                ctrl.branch = 1'b1;
                aluop       = ALUOP_W'(ALUOP_PASSB);
                signext     = {{(DATA_W-19){instr[23]}}, instr[23:5]};
            end
            is_b: begin
                ctrl.uncondbr = 1'b1;
                signext       = {{(DATA_W-26){instr[25]}}, instr[25:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX stage register with valid, hold, flush and load-use bubble.
// Define IDEX_LOAD_USE_STALL_EN to enable the load-use hazard detector.
module id_ex_stage_reg
    import armv8_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               Valid_De,
    input  logic [31:0]        Instruction_De,
    input  logic [DATA_W-1:0]  PC_De,
    input  logic [DATA_W-1:0]  ReadData1_De,
    input  logic [DATA_W-1:0]  ReadData2_De,
    input  logic               Hold,
    input  logic               Flush,
    output logic               Stall_De,
    output logic               Valid_Ex,
    output logic               ALUSrc_Ex,
    output logic [ALUOP_W-1:0] ALUOp_Ex,
    output logic               MemRead_Ex,
    output logic               MemWrite_Ex,
    output logic               MemtoReg_Ex,
    output logic               RegWrite_Ex,
    output logic               Branch_Ex,
    output logic               UncondBr_Ex,
    output logic [REG_AW-1:0]  Rd_Ex,
    output logic [REG_AW-1:0]  Rn_Ex,
    output logic [REG_AW-1:0]  Rm_Ex,
    output logic [DATA_W-1:0]  PC_Ex,
    output logic [DATA_W-1:0]  SignExt_Ex,
    output logic [DATA_W-1:0]  ReadData1_Ex,
    output logic [DATA_W-1:0]  ReadData2_Ex
);

`ifdef IDEX_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    ctrl_t              dec_ctrl;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [REG_AW-1:0]  dec_rd, dec_rn, dec_rm;
    logic               dec_uses_rm;
    logic [DATA_W-1:0]  dec_signext;

    armv8_ctrl_decode #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .instr   (Instruction_De),
        .ctrl    (dec_ctrl),
        .aluop   (dec_aluop),
        .rd      (dec_rd),
        .rn      (dec_rn),
        .rm      (dec_rm),
        .uses_rm (dec_uses_rm),
        .signext (dec_signext)
    );

    ctrl_t              ctrl_d, ctrl_q;
    logic [ALUOP_W-1:0] aluop_d, aluop_q;
    logic [REG_AW-1:0]  rd_d, rd_q, rn_d, rn_q, rm_d, rm_q;
    logic [DATA_W-1:0]  pc_d, pc_q, signext_d, signext_q;
    logic [DATA_W-1:0]  rd1_d, rd1_q, rd2_d, rd2_q;
    logic               hazard;

    // XZR (index 31) never carries a loaded value, so it cannot cause a hazard
    assign hazard = STALL_EN & ctrl_q.valid & ctrl_q.memread & Valid_De
                  & (rd_q != {REG_AW{1'b1}})
                  & ((rd_q == dec_rn) | ((rd_q == dec_rm) & dec_uses_rm));

    assign Stall_De = ~Flush & (Hold | hazard);

    always_comb begin
        ctrl_d    = ctrl_q;
        aluop_d   = aluop_q;
        rd_d      = rd_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        pc_d      = pc_q;
        signext_d = signext_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        if (Flush || !Hold) begin
            rd_d      = dec_rd;
            rn_d      = dec_rn;
            rm_d      = dec_rm;
            pc_d      = PC_De;
            signext_d = dec_signext;
            rd1_d     = ReadData1_De;
            rd2_d     = ReadData2_De;
            if (Flush || hazard || !Valid_De) begin
                ctrl_d  = '0;
                aluop_d = '0;
            end else begin
                ctrl_d       = dec_ctrl;
                ctrl_d.valid = 1'b1;
                aluop_d      = dec_aluop;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ctrl_q    <= '0;
            aluop_q   <= '0;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            pc_q      <= '0;
            signext_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            aluop_q   <= aluop_d;
            rd_q      <= rd_d;
            rn_q      <= rn_d;
            rm_q      <= rm_d;
            pc_q      <= pc_d;
            signext_q <= signext_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
        end
    end

    assign Valid_Ex     = ctrl_q.valid;
    assign ALUSrc_Ex    = ctrl_q.alusrc;
    assign MemRead_Ex   = ctrl_q.memread;
    assign MemWrite_Ex  = ctrl_q.memwrite;
    assign MemtoReg_Ex  = ctrl_q.memtoreg;
    assign RegWrite_Ex  = ctrl_q.regwrite;
    assign Branch_Ex    = ctrl_q.branch;
    assign UncondBr_Ex  = ctrl_q.uncondbr;
    assign ALUOp_Ex     = aluop_q;
    assign Rd_Ex        = rd_q;
    assign Rn_Ex        = rn_q;
    assign Rm_Ex        = rm_q;
    assign PC_Ex        = pc_q;
    assign SignExt_Ex   = signext_q;
    assign ReadData1_Ex = rd1_q;
    assign ReadData2_Ex = rd2_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Valid_De;
    logic [31:0] Instruction_De;
    logic [63:0] PC_De, ReadData1_De, ReadData2_De;
    logic        Hold, Flush;
    logic        Stall_De, Valid_Ex, ALUSrc_Ex;
    logic [2:0]  ALUOp_Ex;
    logic        MemRead_Ex, MemWrite_Ex, MemtoReg_Ex;
    logic        RegWrite_Ex, Branch_Ex, UncondBr_Ex;
    logic [4:0]  Rd_Ex, Rn_Ex, Rm_Ex;
    logic [63:0] PC_Ex, SignExt_Ex, ReadData1_Ex, ReadData2_Ex;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD20  = 32'h8B010054;
    localparam logic [31:0] I_LDUR3  = 32'hF85F8083;
    localparam logic [31:0] I_ADD5   = 32'h8B010065;
    localparam logic [31:0] I_LDURZ  = 32'hF85F809F;
    localparam logic [31:0] I_ADD5Z  = 32'h8B0103E5;
    localparam logic [31:0] I_STUR7  = 32'hF8010047;
    localparam logic [31:0] I_CBZ9   = 32'hB4000089;
    localparam logic [31:0] I_BM1    = 32'h17FFFFFF;
    localparam logic [31:0] I_UNK    = 32'h00000000;

    id_ex_stage_reg dut (
        .clk            (clk),
        .Reset          (Reset),
        .Valid_De       (Valid_De),
        .Instruction_De (Instruction_De),
        .PC_De          (PC_De),
        .ReadData1_De   (ReadData1_De),
        .ReadData2_De   (ReadData2_De),
        .Hold           (Hold),
        .Flush          (Flush),
        .Stall_De       (Stall_De),
        .Valid_Ex       (Valid_Ex),
        .ALUSrc_Ex      (ALUSrc_Ex),
        .ALUOp_Ex       (ALUOp_Ex),
        .MemRead_Ex     (MemRead_Ex),
        .MemWrite_Ex    (MemWrite_Ex),
        .MemtoReg_Ex    (MemtoReg_Ex),
        .RegWrite_Ex    (RegWrite_Ex),
        .Branch_Ex      (Branch_Ex),
        .UncondBr_Ex    (UncondBr_Ex),
        .Rd_Ex          (Rd_Ex),
        .Rn_Ex          (Rn_Ex),
        .Rm_Ex          (Rm_Ex),
        .PC_Ex          (PC_Ex),
        .SignExt_Ex     (SignExt_Ex),
        .ReadData1_Ex   (ReadData1_Ex),
        .ReadData2_Ex   (ReadData2_Ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // controls packed as {valid,alusrc,memread,memwrite,memtoreg,regwrite,branch,uncondbr}
    function automatic logic [7:0] ctl();
        return {Valid_Ex, ALUSrc_Ex, MemRead_Ex, MemWrite_Ex,
                MemtoReg_Ex, RegWrite_Ex, Branch_Ex, UncondBr_Ex};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [63:0] pc, input logic [63:0] a,
                         input logic [63:0] b);
        Valid_De       = v;
        Instruction_De = ins;
        PC_De          = pc;
        ReadData1_De   = a;
        ReadData2_De   = b;
    endtask

    initial begin
        Reset = 1'b0;
        Hold  = 1'b0;
        Flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
        #2;
        chk("reset_ctl", 64'(ctl()), 64'h00);
        chk("reset_stall", 64'(Stall_De), 64'h0);
        @(negedge clk);
        Reset = 1'b1;

        // reset mid-run after a real load
        drive(1'b1, I_ADD20, 64'h100, 64'd5, 64'd7);
        step();
        chk("pre_reset_ctl", 64'(ctl()), 64'h84);
        #2 Reset = 1'b0;
        #1;
        chk("async_reset_ctl", 64'(ctl()), 64'h00);
        chk("async_reset_rd1", ReadData1_Ex, 64'h0);
        chk("async_reset_rd", 64'(Rd_Ex), 64'h0);
        chk("async_reset_pc", PC_Ex, 64'h0);
        #1 Reset = 1'b1;

        // 1: ADD X20,X2,X1
        step();
        chk("add_ctl", 64'(ctl()), 64'h84);
        chk("add_aluop", 64'(ALUOp_Ex), 64'h2);
        chk("add_regs", {49'h0, Rd_Ex, Rn_Ex, Rm_Ex},
            {49'h0, 5'd20, 5'd2, 5'd1});
        chk("add_rd1", ReadData1_Ex, 64'd5);
        chk("add_rd2", ReadData2_Ex, 64'd7);
        chk("add_pc", PC_Ex, 64'h100);

        // 2: LDUR X3,[X4,#-8]
        drive(1'b1, I_LDUR3, 64'h104, 64'd100, 64'd0);
        step();
        chk("ldur_ctl", 64'(ctl()), 64'hEC);
        chk("ldur_aluop", 64'(ALUOp_Ex), 64'h0);
        chk("ldur_sext", SignExt_Ex, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_regs", {49'h0, Rd_Ex, Rn_Ex, Rm_Ex},
            {49'h0, 5'd3, 5'd4, 5'd3});

        // 3: load-use on Rn
        drive(1'b1, I_ADD5, 64'h108, 64'd11, 64'd22);
        #1;
`ifdef IDEX_LOAD_USE_STALL_EN
        chk("lu_stall", 64'(Stall_De), 64'h1);
        step();
        chk("lu_bubble_ctl", 64'(ctl()), 64'h00);
        chk("lu_stall_clear", 64'(Stall_De), 64'h0);
        step();
`else
        chk("lu_nostall", 64'(Stall_De), 64'h0);
        step();
`endif
        chk("lu_add_ctl", 64'(ctl()), 64'h84);
        chk("lu_add_rd", 64'(Rd_Ex), 64'd5);
        chk("lu_add_rn", 64'(Rn_Ex), 64'd3);

        // load into XZR never stalls
        drive(1'b1, I_LDURZ, 64'h10C, 64'd0, 64'd0);
        step();
        chk("ldurz_rd", 64'(Rd_Ex), 64'd31);
        drive(1'b1, I_ADD5Z, 64'h110, 64'd1, 64'd2);
        #1;
        chk("xzr_nostall", 64'(Stall_De), 64'h0);
        step();
        chk("xzr_add_ctl", 64'(ctl()), 64'h84);
        chk("xzr_add_rn", 64'(Rn_Ex), 64'd31);

        // 4: hold for three cycles while ID changes
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 1) ? I_STUR7 : I_CBZ9, 64'(i), 64'(i), 64'(i));
            #1;
            chk("hold_stall", 64'(Stall_De), 64'h1);
            step();
            chk("hold_ctl", 64'(ctl()), 64'h84);
            chk("hold_rd", 64'(Rd_Ex), 64'd5);
            chk("hold_pc", PC_Ex, 64'h110);
            chk("hold_rd1", ReadData1_Ex, 64'd1);
        end
        Hold = 1'b0;
        drive(1'b1, I_STUR7, 64'h200, 64'd8, 64'd9);
        #1;
        chk("unhold_stall", 64'(Stall_De), 64'h0);
        step();
        chk("stur_ctl", 64'(ctl()), 64'hD0);
        chk("stur_sext", SignExt_Ex, 64'd16);
        chk("stur_rm", 64'(Rm_Ex), 64'd7);
        chk("stur_pc", PC_Ex, 64'h200);

        // 5: flush beats hold and a pending hazard
        drive(1'b1, I_LDUR3, 64'h204, 64'd0, 64'd0);
        step();
        drive(1'b1, I_ADD5, 64'h208, 64'd3, 64'd4);
        Hold  = 1'b1;
        Flush = 1'b1;
        #1;
        chk("flush_stall", 64'(Stall_De), 64'h0);
        step();
        chk("flush_ctl", 64'(ctl()), 64'h00);
        chk("flush_aluop", 64'(ALUOp_Ex), 64'h0);
        Hold  = 1'b0;
        Flush = 1'b0;

        // 6: B #-1 and CBZ X9,#4
        drive(1'b1, I_BM1, 64'h300, 64'd0, 64'd0);
        step();
        chk("b_ctl", 64'(ctl()), 64'h81);
        chk("b_sext", SignExt_Ex, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, I_CBZ9, 64'h304, 64'd0, 64'd0);
        step();
        chk("cbz_ctl", 64'(ctl()), 64'h82);
        chk("cbz_aluop", 64'(ALUOp_Ex), 64'h1);
        chk("cbz_sext", SignExt_Ex, 64'd4);
        chk("cbz_rm", 64'(Rm_Ex), 64'd9);

        // unknown opcode stays valid; Valid_De=0 kills controls
        drive(1'b1, I_UNK, 64'h308, 64'd0, 64'd0);
        step();
        chk("unk_ctl", 64'(ctl()), 64'h80);
        drive(1'b0, I_ADD20, 64'h30C, 64'd5, 64'd6);
        step();
        chk("inv_ctl", 64'(ctl()), 64'h00);
        chk("inv_aluop", 64'(ALUOp_Ex), 64'h0);
        chk("inv_rd", 64'(Rd_Ex), 64'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
